// File: rtl/lightsaber_blade_driver.sv
// rtl/lightsaber_blade_driver.sv - blade length sequencer: OFF/EXTEND/ON/RETRACT with prescaled stepping.
// Optional BLADE_FLICKER_EN: mode 11 in ON flickers between MAX_LEN and MAX_LEN-1.
module lightsaber_blade_driver #(
   parameter int LEN_W    = 4,
   parameter int MAX_LEN  = 15,
   parameter int STEP_DIV = 4
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [1:0]       cfg,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   output logic [LEN_W-1:0] blade_len,
   output logic [1:0]       blade_mode,
   output logic             busy
);

   localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [PW-1:0]    PRE_LAST = PW'(STEP_DIV - 1);
   localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);

   typedef enum logic [1:0] {S_OFF, S_EXTEND, S_ON, S_RETRACT} state_t;

   state_t        state;
   logic [PW-1:0] pre;
   logic          accept;
   logic          step;

   assign cfg_ready = (state == S_OFF) || (state == S_ON);
   assign busy      = (state == S_EXTEND) || (state == S_RETRACT);
   assign accept    = cfg_valid && cfg_ready;
   assign step      = (pre == PRE_LAST);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= S_OFF;
         pre        <= '0;
         blade_len  <= '0;
         blade_mode <= 2'b00;
      end else begin
         case (state)
            S_OFF: begin
               if (accept && cfg != 2'b00) begin
                  blade_mode <= cfg;
                  pre        <= '0;
                  state      <= S_EXTEND;
               end
            end
            S_EXTEND: begin
               if (step) begin
                  pre       <= '0;
                  blade_len <= blade_len + 1'b1;
                  if (blade_len >= LEN_MAX - 1'b1)
                     state <= S_ON;
               end else begin
                  pre <= pre + 1'b1;
               end
            end
            S_ON: begin
               if (accept && cfg == 2'b00) begin
                  pre   <= '0;
                  state <= S_RETRACT;
               end else begin
                  if (accept && cfg != blade_mode)
                     blade_mode <= cfg;
`ifdef BLADE_FLICKER_EN
                  // Prescaler free-runs in ON so the flicker keeps the step cadence.
                  pre <= step ? '0 : pre + 1'b1;
                  if (step && blade_mode == 2'b11)
                     blade_len <= (blade_len == LEN_MAX) ? LEN_MAX - 1'b1 : LEN_MAX;
`endif
               end
            end
            S_RETRACT: begin
               if (step) begin
                  pre <= '0;
                  if (blade_len <= 1) begin
                     blade_len  <= '0;
                     blade_mode <= 2'b00;
                     state      <= S_OFF;
                  end else begin
                     blade_len <= blade_len - 1'b1;
                  end
               end else begin
                  pre <= pre + 1'b1;
               end
            end
            default: state <= S_OFF;
         endcase
      end
   end

endmodule

// File: tb/tb_lightsaber_blade_driver.sv
// tb/tb_lightsaber_blade_driver.sv - directed-vector bench for lightsaber_blade_driver (STEP_DIV=4 and STEP_DIV=1 instances).
module tb_lightsaber_blade_driver;

   logic       clk = 1'b0;
   logic       rstn = 1'b1;
   logic [1:0] cfg = 2'b00;
   logic       cfg_valid = 1'b0;
   logic       cfg_ready;
   logic [3:0] blade_len;
   logic [1:0] blade_mode;
   logic       busy;

   logic [1:0] cfg1 = 2'b00;
   logic       cfg_valid1 = 1'b0;
   logic       cfg_ready1;
   logic [3:0] blade_len1;
   logic [1:0] blade_mode1;
   logic       busy1;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   lightsaber_blade_driver #(.LEN_W(4), .MAX_LEN(15), .STEP_DIV(4)) dut (
      .clk(clk), .rstn(rstn), .cfg(cfg), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .blade_len(blade_len), .blade_mode(blade_mode), .busy(busy)
   );

   lightsaber_blade_driver #(.LEN_W(4), .MAX_LEN(15), .STEP_DIV(1)) dut1 (
      .clk(clk), .rstn(rstn), .cfg(cfg1), .cfg_valid(cfg_valid1), .cfg_ready(cfg_ready1),
      .blade_len(blade_len1), .blade_mode(blade_mode1), .busy(busy1)
   );

   task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic offer(input logic [1:0] c);
      cfg = c;
      cfg_valid = 1'b1;
      tick(1);
      cfg_valid = 1'b0;
   endtask

   initial begin
      #2 rstn = 1'b0;
      #1;
      expect_eq("rst_len", blade_len, 0);
      expect_eq("rst_mode", blade_mode, 0);
      expect_eq("rst_busy", busy, 0);
      expect_eq("rst_ready", cfg_ready, 1);
      tick(2);
      rstn = 1'b1;

      // STEP_DIV=1 instance: one step per cycle
      cfg1 = 2'b01;
      cfg_valid1 = 1'b1;
      tick(1);
      cfg_valid1 = 1'b0;
      expect_eq("d1_busy", busy1, 1);
      tick(1);
      expect_eq("d1_len1", blade_len1, 1);
      tick(13);
      expect_eq("d1_len14", blade_len1, 14);
      expect_eq("d1_busy14", busy1, 1);
      tick(1);
      expect_eq("d1_len15", blade_len1, 15);
      expect_eq("d1_on", busy1, 0);

      // Ignite
      offer(2'b01);
      expect_eq("ign_busy", busy, 1);
      expect_eq("ign_ready", cfg_ready, 0);
      expect_eq("ign_mode", blade_mode, 1);
      tick(3);
      expect_eq("ign_len_3", blade_len, 0);
      tick(1);
      expect_eq("ign_len_4", blade_len, 1);
      tick(55);
      expect_eq("ign_len_59", blade_len, 14);
      expect_eq("ign_busy_59", busy, 1);
      tick(1);
      expect_eq("ign_len_60", blade_len, 15);
      expect_eq("ign_on_busy", busy, 0);
      expect_eq("ign_on_ready", cfg_ready, 1);

      // Mode switch in ON
      offer(2'b10);
      expect_eq("sw_mode", blade_mode, 2);
      expect_eq("sw_len", blade_len, 15);
      expect_eq("sw_busy", busy, 0);
      offer(2'b10);
      expect_eq("same_mode", blade_mode, 2);

      // Retract
      offer(2'b00);
      expect_eq("ret_busy", busy, 1);
      expect_eq("ret_len0", blade_len, 15);
      tick(4);
      expect_eq("ret_len4", blade_len, 14);
      tick(55);
      expect_eq("ret_len59", blade_len, 1);
      expect_eq("ret_mode59", blade_mode, 2);
      tick(1);
      expect_eq("ret_len60", blade_len, 0);
      expect_eq("ret_busy60", busy, 0);
      expect_eq("ret_mode60", blade_mode, 0);

      offer(2'b00);
      expect_eq("off_noop_busy", busy, 0);
      expect_eq("off_noop_mode", blade_mode, 0);

      // Backpressure: retract request held through EXTEND
      offer(2'b01);
      cfg = 2'b00;
      cfg_valid = 1'b1;
      tick(30);
      expect_eq("bp_len30", blade_len, 7);
      expect_eq("bp_busy30", busy, 1);
      tick(29);
      expect_eq("bp_len59", blade_len, 14);
      tick(1);
      expect_eq("bp_on_len", blade_len, 15);
      expect_eq("bp_on_ready", cfg_ready, 1);
      tick(1);
      cfg_valid = 1'b0;
      expect_eq("bp_ret_busy", busy, 1);
      expect_eq("bp_ret_len", blade_len, 15);
      expect_eq("bp_ret_mode", blade_mode, 1);
      tick(60);
      expect_eq("bp_off_len", blade_len, 0);
      expect_eq("bp_off_busy", busy, 0);

      // Reset mid-extend, asynchronous
      offer(2'b10);
      tick(28);
      expect_eq("mid_len7", blade_len, 7);
      #2 rstn = 1'b0;
      #1;
      expect_eq("arst_len", blade_len, 0);
      expect_eq("arst_mode", blade_mode, 0);
      expect_eq("arst_busy", busy, 0);
      expect_eq("arst_ready", cfg_ready, 1);
      #2 rstn = 1'b1;
      offer(2'b11);
      expect_eq("post_busy", busy, 1);
      expect_eq("post_mode", blade_mode, 3);
      tick(60);
      expect_eq("m11_len", blade_len, 15);
      expect_eq("m11_busy", busy, 0);
      tick(4);
`ifdef BLADE_FLICKER_EN
      expect_eq("m11_len_a", blade_len, 14);
`else
      expect_eq("m11_len_a", blade_len, 15);
`endif
      tick(4);
      expect_eq("m11_len_b", blade_len, 15);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
